// File: rtl/acc_pkg.sv
// Shared encodings for the frame accumulator: MODE commands and FSM states.
package acc_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_ACC   = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/register_n_bit.sv
// Generic enabled register with synchronous active-high reset and inverted output.
module register_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar
);

  always_ff @(posedge CLK) begin
    if (RST)     Q <= '0;
    else if (EN) Q <= D;
  end

  assign Q_bar = ~Q;

endmodule

// File: rtl/acc_register_n_bit.sv
// Framed signed accumulator: load/accumulate/clear with frame counter and sticky overflow.
// Optional macro ACC_SAT_EN: saturate on overflow instead of wrapping.
//
// state    | meaning
// ST_IDLE  | cleared or reset, no accumulation in this frame yet
// ST_ACCUM | frame in progress, CNT < COUNT_MAX
// ST_FULL  | frame complete, accumulate commands ignored, DONE high
module acc_register_n_bit #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int COUNT_MAX = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  In,
  input  logic                 EN,
  input  logic [1:0]           MODE,
  output logic [ACC_WIDTH-1:0] Q,
  output logic [ACC_WIDTH-1:0] Q_bar,
  output logic [7:0]           CNT,
  output logic                 OVF,
  output logic                 DONE
);
  import acc_pkg::*;

  localparam int          MSB      = ACC_WIDTH - 1;
  localparam logic [7:0]  CNT_LAST = 8'(COUNT_MAX);

  state_e               state;
  logic [7:0]           cnt_r;
  logic                 ovf_r;
  logic                 done_r;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 acc_we;
  logic                 sum_ovf;
  logic [7:0]           cnt_inc;

  assign in_ext  = ACC_WIDTH'(signed'(In));
  assign sum     = Q + in_ext;
  assign sum_ovf = (Q[MSB] == in_ext[MSB]) && (sum[MSB] != Q[MSB]);
  assign cnt_inc = cnt_r + 8'd1;

  // Next accumulator value and write strobe for the storage register.
  always_comb begin
    acc_we   = 1'b0;
    acc_next = sum;
    if (EN) begin
      case (mode_e'(MODE))
        MODE_LOAD: begin
          acc_we   = 1'b1;
          acc_next = in_ext;
        end
        MODE_ACC: begin
          acc_we = (state != ST_FULL);
`ifdef ACC_SAT_EN
          if (sum_ovf)
            acc_next = in_ext[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
          acc_next = sum;
`endif
        end
        MODE_CLEAR: begin
          acc_we   = 1'b1;
          acc_next = '0;
        end
        default: ;
      endcase
    end
  end

  register_n_bit #(.WIDTH(ACC_WIDTH)) u_acc_reg (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (acc_we),
    .D     (acc_next),
    .Q     (Q),
    .Q_bar (Q_bar)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt_r  <= 8'd0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (EN) begin
      case (mode_e'(MODE))
        MODE_LOAD: begin
          cnt_r <= 8'd1;
          ovf_r <= 1'b0;
          if (COUNT_MAX == 1) begin
            state  <= ST_FULL;
            done_r <= 1'b1;
          end else begin
            state  <= ST_ACCUM;
            done_r <= 1'b0;
          end
        end
        MODE_ACC: begin
          if (state != ST_FULL) begin
            cnt_r <= cnt_inc;
            if (sum_ovf) ovf_r <= 1'b1;
            if (cnt_inc == CNT_LAST) begin
              state  <= ST_FULL;
              done_r <= 1'b1;
            end else begin
              state  <= ST_ACCUM;
              done_r <= 1'b0;
            end
          end
        end
        MODE_CLEAR: begin
          state  <= ST_IDLE;
          cnt_r  <= 8'd0;
          ovf_r  <= 1'b0;
          done_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign CNT  = cnt_r;
  assign OVF  = ovf_r;
  assign DONE = done_r;

endmodule
